// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline front end: pcsource encodings,
// the default bubble instruction, fetch FSM states and small PC helpers.
package pipe_pkg;

    // pcsource encodings driven by decode
    localparam logic [1:0] PC_SEQ = 2'b00;  // pc + 4
    localparam logic [1:0] PC_BR  = 2'b01;  // branch target (bpc)
    localparam logic [1:0] PC_JR  = 2'b10;  // register target (rpc)
    localparam logic [1:0] PC_J   = 2'b11;  // jump target (jpc)

    // All-zero word decodes as sll $0,$0,0, i.e. a harmless bubble
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Fetch FSM encoding
    localparam logic [0:0] ST_FETCH = 1'b0;  // request outstanding, imem_req=1
    localparam logic [0:0] ST_HOLD  = 1'b1;  // word parked in buffer, no request

    // Sequential successor of a PC; wraps modulo 2^32
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/mux4x32.sv
// Four-way 32-bit selector used to pick the next-PC candidate from pcsource.
module mux4x32
    import pipe_pkg::*;
(
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic [31:0] a2,
    input  logic [31:0] a3,
    input  logic [1:0]  s,
    output logic [31:0] y
);

    // Pure select; encoding follows the pcsource constants
    always_comb begin
        y = a0;
        case (s)
            PC_SEQ:  y = a0;
            PC_BR:   y = a1;
            PC_JR:   y = a2;
            PC_J:    y = a3;
            default: y = a0;
        endcase
    end

endmodule

// File: rtl/pipefetch.sv
// Instruction fetch stage plus IF/ID register. Issues fetches at pc to a
// memory that may insert wait states, parks a fetched word while decode
// stalls, and applies decode redirects after the single delay slot.
module pipefetch
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_WORD
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic        wpcir,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] dpc4,
    output logic [31:0] inst
);

    logic [0:0]  state_q,  state_d;
    logic [31:0] pc_q,     pc_d;
    logic [31:0] inst_q,   inst_d;
    logic [31:0] dpc4_q,   dpc4_d;
    logic [31:0] buf_q,    buf_d;
    logic [31:0] bufpc4_q, bufpc4_d;
    logic [31:0] rdpc_q,   rdpc_d;   // redirect target latched during a wait state
    logic        rdv_q,    rdv_d;    // redirect pending, applied when delay slot lands

    logic [31:0] pc4;
    logic [31:0] target;
    logic [31:0] npc;

    assign pc4 = pc_plus4(pc_q);

    mux4x32 u_npc_mux (
        .a0 (pc4),
        .a1 (bpc),
        .a2 (rpc),
        .a3 (jpc),
        .s  (pcsource),
        .y  (target)
    );

    // A redirect seen while the delay slot was still being fetched wins,
    // since decode is then looking at a bubble and drives PC_SEQ
    assign npc = rdv_q ? rdpc_q : target;

    // Fetch-side outputs decode directly from state and pc
    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;

    assign pc   = pc_q;
    assign dpc4 = dpc4_q;
    assign inst = inst_q;

    // Next-state rules for the fetch FSM and the IF/ID register
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        dpc4_d   = dpc4_q;
        buf_d    = buf_q;
        bufpc4_d = bufpc4_q;
        rdpc_d   = rdpc_q;
        rdv_d    = rdv_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    if (wpcir) begin
                        inst_d = imem_rdata;
                        dpc4_d = pc4;
                        pc_d   = npc;
                        rdv_d  = 1'b0;
                    end else begin
                        // Decode is stalled: park the word, stop requesting
                        buf_d    = imem_rdata;
                        bufpc4_d = pc4;
                        state_d  = ST_HOLD;
                    end
                end else if (wpcir) begin
                    // Wait state: feed a bubble and remember any redirect,
                    // because decode will see that bubble next cycle
                    inst_d = NOP_INST;
                    dpc4_d = 32'h0;
                    if ((pcsource != PC_SEQ) && !rdv_q) begin
                        rdpc_d = target;
                        rdv_d  = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                // imem_ready here is a protocol violation and is ignored
                if (wpcir) begin
                    inst_d  = buf_q;
                    dpc4_d  = bufpc4_q;
                    pc_d    = npc;
                    rdv_d   = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            inst_q   <= NOP_INST;
            dpc4_q   <= 32'h0;
            buf_q    <= 32'h0;
            bufpc4_q <= 32'h0;
            rdpc_q   <= 32'h0;
            rdv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            dpc4_q   <= dpc4_d;
            buf_q    <= buf_d;
            bufpc4_q <= bufpc4_d;
            rdpc_q   <= rdpc_d;
            rdv_q    <= rdv_d;
        end
    end

endmodule

// File: tb/tb_pipefetch.sv
// Directed bench for pipefetch. Instruction memory returns 0xE000_0000 | addr
// so every expected IR word follows from its fetch address.
module tb_pipefetch;

    logic        clock;
    logic        resetn;
    logic [1:0]  pcsource;
    logic [31:0] bpc, rpc, jpc;
    logic        wpcir;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] pc, dpc4, inst;

    int total = 0;
    int bad   = 0;

    pipefetch dut (
        .clock      (clock),
        .resetn     (resetn),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .rpc        (rpc),
        .jpc        (jpc),
        .wpcir      (wpcir),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .pc         (pc),
        .dpc4       (dpc4),
        .inst       (inst)
    );

    assign imem_rdata = 32'hE000_0000 | imem_addr;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // advance one clock edge and settle
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b1; pcsource = 2'b00; bpc = 0; rpc = 0; jpc = 0;
        wpcir = 1'b1; imem_ready = 1'b0;
        #1 resetn = 1'b0;
        #1;
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
        total++; if (inst !== 32'h0) begin bad++; $display("FAIL reset_inst got %h want %h", inst, 32'h0); end
        total++; if (dpc4 !== 32'h0) begin bad++; $display("FAIL reset_dpc4 got %h want %h", dpc4, 32'h0); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req got %b want 1", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL first_addr got %h want %h", imem_addr, 32'h0); end
    endtask

    task automatic test_straight();
        imem_ready = 1'b1;
        step();
        total++; if (inst !== 32'hE000_0000) begin bad++; $display("FAIL seq0_inst got %h want %h", inst, 32'hE000_0000); end
        total++; if (dpc4 !== 32'h4) begin bad++; $display("FAIL seq0_dpc4 got %h want %h", dpc4, 32'h4); end
        total++; if (pc !== 32'h4) begin bad++; $display("FAIL seq0_pc got %h want %h", pc, 32'h4); end
        step();
        total++; if (inst !== 32'hE000_0004) begin bad++; $display("FAIL seq1_inst got %h want %h", inst, 32'hE000_0004); end
        total++; if (dpc4 !== 32'h8) begin bad++; $display("FAIL seq1_dpc4 got %h want %h", dpc4, 32'h8); end
        step();
        total++; if (inst !== 32'hE000_0008) begin bad++; $display("FAIL seq2_inst got %h want %h", inst, 32'hE000_0008); end
        total++; if (dpc4 !== 32'hC) begin bad++; $display("FAIL seq2_dpc4 got %h want %h", dpc4, 32'hC); end
        total++; if (imem_addr !== 32'hC) begin bad++; $display("FAIL seq2_addr got %h want %h", imem_addr, 32'hC); end
    endtask

    task automatic test_branch_zero_wait();
        pcsource = 2'b01; bpc = 32'h40;
        step();
        total++; if (inst !== 32'hE000_000C) begin bad++; $display("FAIL br_slot_inst got %h want %h", inst, 32'hE000_000C); end
        total++; if (dpc4 !== 32'h10) begin bad++; $display("FAIL br_slot_dpc4 got %h want %h", dpc4, 32'h10); end
        total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL br_target got %h want %h", imem_addr, 32'h40); end
        pcsource = 2'b00;
        step();
        total++; if (inst !== 32'hE000_0040) begin bad++; $display("FAIL br_tgt_inst got %h want %h", inst, 32'hE000_0040); end
        total++; if (pc !== 32'h44) begin bad++; $display("FAIL br_after_pc got %h want %h", pc, 32'h44); end
    endtask

    task automatic test_branch_wait();
        pcsource = 2'b01; bpc = 32'h80; imem_ready = 1'b0;
        step();
        total++; if (inst !== 32'h0) begin bad++; $display("FAIL bw_nop1 got %h want %h", inst, 32'h0); end
        total++; if (dpc4 !== 32'h0) begin bad++; $display("FAIL bw_nop1_dpc4 got %h want %h", dpc4, 32'h0); end
        total++; if (imem_addr !== 32'h44) begin bad++; $display("FAIL bw_addr_stable got %h want %h", imem_addr, 32'h44); end
        pcsource = 2'b00;
        step();
        total++; if (inst !== 32'h0) begin bad++; $display("FAIL bw_nop2 got %h want %h", inst, 32'h0); end
        total++; if (imem_addr !== 32'h44) begin bad++; $display("FAIL bw_addr_stable2 got %h want %h", imem_addr, 32'h44); end
        imem_ready = 1'b1;
        step();
        total++; if (inst !== 32'hE000_0044) begin bad++; $display("FAIL bw_slot_inst got %h want %h", inst, 32'hE000_0044); end
        total++; if (imem_addr !== 32'h80) begin bad++; $display("FAIL bw_target got %h want %h", imem_addr, 32'h80); end
        step();
        total++; if (inst !== 32'hE000_0080) begin bad++; $display("FAIL bw_tgt_inst got %h want %h", inst, 32'hE000_0080); end
        total++; if (pc !== 32'h84) begin bad++; $display("FAIL bw_redirect_clear got %h want %h", pc, 32'h84); end
    endtask

    task automatic test_stall_jump();
        wpcir = 1'b0;
        step();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL hold_req got %b want 0", imem_req); end
        total++; if (inst !== 32'hE000_0080) begin bad++; $display("FAIL hold_inst got %h want %h", inst, 32'hE000_0080); end
        total++; if (pc !== 32'h84) begin bad++; $display("FAIL hold_pc got %h want %h", pc, 32'h84); end
        pcsource = 2'b01; bpc = 32'h300;   // ignored while stalled
        step();
        step();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL hold3_req got %b want 0", imem_req); end
        total++; if (inst !== 32'hE000_0080) begin bad++; $display("FAIL hold3_inst got %h want %h", inst, 32'hE000_0080); end
        total++; if (dpc4 !== 32'h84) begin bad++; $display("FAIL hold3_dpc4 got %h want %h", dpc4, 32'h84); end
        wpcir = 1'b1; pcsource = 2'b11; jpc = 32'h0040_0000;
        step();
        total++; if (inst !== 32'hE000_0084) begin bad++; $display("FAIL unhold_inst got %h want %h", inst, 32'hE000_0084); end
        total++; if (dpc4 !== 32'h88) begin bad++; $display("FAIL unhold_dpc4 got %h want %h", dpc4, 32'h88); end
        total++; if (imem_addr !== 32'h0040_0000) begin bad++; $display("FAIL j_target got %h want %h", imem_addr, 32'h0040_0000); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL unhold_req got %b want 1", imem_req); end
        pcsource = 2'b00;
        step();
        total++; if (inst !== 32'hE040_0000) begin bad++; $display("FAIL j_tgt_inst got %h want %h", inst, 32'hE040_0000); end
        total++; if (pc !== 32'h0040_0004) begin bad++; $display("FAIL j_after_pc got %h want %h", pc, 32'h0040_0004); end
    endtask

    task automatic test_jr();
        pcsource = 2'b10; rpc = 32'h1000;
        step();
        total++; if (inst !== 32'hE040_0004) begin bad++; $display("FAIL jr_slot_inst got %h want %h", inst, 32'hE040_0004); end
        total++; if (imem_addr !== 32'h1000) begin bad++; $display("FAIL jr_target got %h want %h", imem_addr, 32'h1000); end
        pcsource = 2'b00;
        step();
        total++; if (inst !== 32'hE000_1000) begin bad++; $display("FAIL jr_tgt_inst got %h want %h", inst, 32'hE000_1000); end
        total++; if (dpc4 !== 32'h1004) begin bad++; $display("FAIL jr_tgt_dpc4 got %h want %h", dpc4, 32'h1004); end
    endtask

    task automatic test_wrap();
        pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
        step();
        pcsource = 2'b00;
        step();
        total++; if (inst !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_inst got %h want %h", inst, 32'hFFFF_FFFC); end
        total++; if (dpc4 !== 32'h0) begin bad++; $display("FAIL wrap_dpc4 got %h want %h", dpc4, 32'h0); end
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got %h want %h", pc, 32'h0); end
        step();
        total++; if (inst !== 32'hE000_0000) begin bad++; $display("FAIL wrap_next got %h want %h", inst, 32'hE000_0000); end
    endtask

    task automatic test_reset_mid_wait();
        // pc is 0x4 here; start a wait state and latch a branch redirect
        imem_ready = 1'b0; pcsource = 2'b01; bpc = 32'h200;
        step();
        pcsource = 2'b00;
        total++; if (pc !== 32'h4) begin bad++; $display("FAIL rmw_pc_pre got %h want %h", pc, 32'h4); end
        #2 resetn = 1'b0;
        #1;
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL rmw_async_pc got %h want %h", pc, 32'h0); end
        total++; if (inst !== 32'h0) begin bad++; $display("FAIL rmw_async_inst got %h want %h", inst, 32'h0); end
        imem_ready = 1'b1;   // late strobe while in reset must be ignored
        step();
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL rmw_ready_ignored got %h want %h", pc, 32'h0); end
        @(negedge clock);
        resetn = 1'b1;
        step();
        total++; if (inst !== 32'hE000_0000) begin bad++; $display("FAIL rmw_restart_inst got %h want %h", inst, 32'hE000_0000); end
        total++; if (pc !== 32'h4) begin bad++; $display("FAIL rmw_redirect_cleared got %h want %h", pc, 32'h4); end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_branch_zero_wait();
        test_branch_wait();
        test_stall_jump();
        test_jr();
        test_wrap();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
